// File: rtl/decode_execute_reg_if.sv
// Decode-to-execute boundary bundle: decode-stage fields in, execute-stage
// registered fields out, plus the execute-side feedback used by the flag register.
interface decode_execute_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 4
);
    // Pipeline control
    logic                  StallE;
    logic                  FlushE;

    // Decode-stage fields
    logic                  PCSrcD;
    logic                  RegWriteD;
    logic                  MemtoRegD;
    logic                  MemWriteD;
    logic                  BranchD;
    logic                  ALUSrcD;
    logic                  NoWriteD;
    logic [2:0]            ALUControlD;
    logic [1:0]            FlagWriteD;
    logic [3:0]            CondD;
    logic [DATA_WIDTH-1:0] RD1D;
    logic [DATA_WIDTH-1:0] RD2D;
    logic [DATA_WIDTH-1:0] ExtImmD;
    logic [REG_ADDR_W-1:0] WA3D;
    logic [REG_ADDR_W-1:0] RA1D;
    logic [REG_ADDR_W-1:0] RA2D;

    // Execute-stage feedback
    logic [3:0]            ALUFlagsE;
    logic                  CondExE;

    // Execute-stage registered fields
    logic                  PCSrcE;
    logic                  RegWriteE;
    logic                  MemtoRegE;
    logic                  MemWriteE;
    logic                  BranchE;
    logic                  ALUSrcE;
    logic                  NoWriteE;
    logic [2:0]            ALUControlE;
    logic [1:0]            FlagWriteE;
    logic [3:0]            CondE;
    logic [DATA_WIDTH-1:0] RD1E;
    logic [DATA_WIDTH-1:0] RD2E;
    logic [DATA_WIDTH-1:0] ExtImmE;
    logic [REG_ADDR_W-1:0] WA3E;
    logic [REG_ADDR_W-1:0] RA1E;
    logic [REG_ADDR_W-1:0] RA2E;
    logic                  ValidE;
    logic [3:0]            FlagsE;

    // Pipeline side that produces decode fields and consumes execute fields
    modport master (
        output StallE, FlushE,
        output PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD,
        output ALUControlD, FlagWriteD, CondD,
        output RD1D, RD2D, ExtImmD, WA3D, RA1D, RA2D,
        output ALUFlagsE, CondExE,
        input  PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, NoWriteE,
        input  ALUControlE, FlagWriteE, CondE,
        input  RD1E, RD2E, ExtImmE, WA3E, RA1E, RA2E,
        input  ValidE, FlagsE
    );

    // The pipeline register itself
    modport slave (
        input  StallE, FlushE,
        input  PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD,
        input  ALUControlD, FlagWriteD, CondD,
        input  RD1D, RD2D, ExtImmD, WA3D, RA1D, RA2D,
        input  ALUFlagsE, CondExE,
        output PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, NoWriteE,
        output ALUControlE, FlagWriteE, CondE,
        output RD1E, RD2E, ExtImmE, WA3E, RA1E, RA2E,
        output ValidE, FlagsE
    );
endinterface

// File: rtl/decode_execute_reg.sv
// Decode/execute pipeline register with stall and bubble insertion, plus the
// architectural {N,Z,C,V} flag register written by the instruction leaving E.
module decode_execute_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    decode_execute_reg_if.slave deIf
);

    logic                  pcSrcQ;
    logic                  regWriteQ;
    logic                  memtoRegQ;
    logic                  memWriteQ;
    logic                  branchQ;
    logic                  aluSrcQ;
    logic                  noWriteQ;
    logic [2:0]            aluControlQ;
    logic [1:0]            flagWriteQ;
    logic [3:0]            condQ;
    logic [DATA_WIDTH-1:0] rd1Q;
    logic [DATA_WIDTH-1:0] rd2Q;
    logic [DATA_WIDTH-1:0] extImmQ;
    logic [REG_ADDR_W-1:0] wa3Q;
    logic [REG_ADDR_W-1:0] ra1Q;
    logic [REG_ADDR_W-1:0] ra2Q;
    logic                  validQ;
    logic [3:0]            flagsQ;
    logic                  flagUpd;

    // Pipeline fields: reset > flush (bubble) > stall (hold) > load.
    always_ff @(posedge clk) begin
        if (!reset || deIf.FlushE) begin
            pcSrcQ      <= 1'b0;
            regWriteQ   <= 1'b0;
            memtoRegQ   <= 1'b0;
            memWriteQ   <= 1'b0;
            branchQ     <= 1'b0;
            aluSrcQ     <= 1'b0;
            noWriteQ    <= 1'b0;
            aluControlQ <= '0;
            flagWriteQ  <= '0;
            condQ       <= '0;
            rd1Q        <= '0;
            rd2Q        <= '0;
            extImmQ     <= '0;
            wa3Q        <= '0;
            ra1Q        <= '0;
            ra2Q        <= '0;
            validQ      <= 1'b0;
        end else if (!deIf.StallE) begin
            pcSrcQ      <= deIf.PCSrcD;
            regWriteQ   <= deIf.RegWriteD;
            memtoRegQ   <= deIf.MemtoRegD;
            memWriteQ   <= deIf.MemWriteD;
            branchQ     <= deIf.BranchD;
            aluSrcQ     <= deIf.ALUSrcD;
            noWriteQ    <= deIf.NoWriteD;
            aluControlQ <= deIf.ALUControlD;
            flagWriteQ  <= deIf.FlagWriteD;
            condQ       <= deIf.CondD;
            rd1Q        <= deIf.RD1D;
            rd2Q        <= deIf.RD2D;
            extImmQ     <= deIf.ExtImmD;
            wa3Q        <= deIf.WA3D;
            ra1Q        <= deIf.RA1D;
            ra2Q        <= deIf.RA2D;
            validQ      <= 1'b1;
        end
    end

    // Flags are written by the instruction currently in E, on the edge it
    // leaves; a stalled instruction has not left yet, and flush only replaces
    // the incoming instruction so it must not block the outgoing one's write.
    assign flagUpd = reset & validQ & deIf.CondExE & ~deIf.StallE;

    // Architectural flag register with per-pair write enables.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flagsQ <= 4'b0000;
        end else if (flagUpd) begin
            if (flagWriteQ[1]) flagsQ[3:2] <= deIf.ALUFlagsE[3:2];
            if (flagWriteQ[0]) flagsQ[1:0] <= deIf.ALUFlagsE[1:0];
        end
    end

    assign deIf.PCSrcE      = pcSrcQ;
    assign deIf.RegWriteE   = regWriteQ;
    assign deIf.MemtoRegE   = memtoRegQ;
    assign deIf.MemWriteE   = memWriteQ;
    assign deIf.BranchE     = branchQ;
    assign deIf.ALUSrcE     = aluSrcQ;
    assign deIf.NoWriteE    = noWriteQ;
    assign deIf.ALUControlE = aluControlQ;
    assign deIf.FlagWriteE  = flagWriteQ;
    assign deIf.CondE       = condQ;
    assign deIf.RD1E        = rd1Q;
    assign deIf.RD2E        = rd2Q;
    assign deIf.ExtImmE     = extImmQ;
    assign deIf.WA3E        = wa3Q;
    assign deIf.RA1E        = ra1Q;
    assign deIf.RA2E        = ra2Q;
    assign deIf.ValidE      = validQ;
    assign deIf.FlagsE      = flagsQ;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed vector bench for decode_execute_reg: pipeline load/hold/bubble
// behaviour and the condition-gated flag register.
module tb_decode_execute_reg;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SIDE_W = 6 + 3 + DW + DW + AW + AW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    decode_execute_reg_if #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) deIf ();

    decode_execute_reg #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .deIf  (deIf)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        regWr;
        logic [1:0]  fw;
        logic [3:0]  cond;
        logic [3:0]  wa3;
        logic [31:0] rd1;
        logic [3:0]  aluF;
        logic        condEx;
        logic        expValid;
        logic        expRegWr;
        logic [1:0]  expFw;
        logic [3:0]  expCond;
        logic [3:0]  expWa3;
        logic [31:0] expRd1;
        logic [3:0]  expFlags;
    } vec_t;

    vec_t vecs [19];

    // Remaining decode fields are a fixed function of RD1D that maps 0 to 0,
    // so the expected E value of every field follows from the expected RD1E.
    function automatic logic [SIDE_W-1:0] sideOf(input logic [31:0] x);
        return {x[0], x[1], x[2], x[3], x[4], x[5], x[8:6],
                {x[15:0], x[31:16]}, x ^ {x[30:0], 1'b0}, x[11:8], x[15:12]};
    endfunction

    function automatic logic [SIDE_W-1:0] sideE();
        return {deIf.PCSrcE, deIf.MemtoRegE, deIf.MemWriteE, deIf.BranchE,
                deIf.ALUSrcE, deIf.NoWriteE, deIf.ALUControlE,
                deIf.RD2E, deIf.ExtImmE, deIf.RA1E, deIf.RA2E};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic driveD(input logic regWr, input logic [1:0] fw, input logic [3:0] cond,
                          input logic [3:0] wa3, input logic [31:0] rd1);
        logic [SIDE_W-1:0] s;
        s = sideOf(rd1);
        deIf.RegWriteD = regWr;
        deIf.FlagWriteD = fw;
        deIf.CondD = cond;
        deIf.WA3D = wa3;
        deIf.RD1D = rd1;
        {deIf.PCSrcD, deIf.MemtoRegD, deIf.MemWriteD, deIf.BranchD,
         deIf.ALUSrcD, deIf.NoWriteD, deIf.ALUControlD,
         deIf.RD2D, deIf.ExtImmD, deIf.RA1D, deIf.RA2D} = s;
    endtask

    task automatic checkE(input string tag, input logic valid, input logic regWr,
                          input logic [1:0] fw, input logic [3:0] cond, input logic [3:0] wa3,
                          input logic [31:0] rd1, input logic [3:0] flags);
        check({tag, ".ValidE"},     128'(deIf.ValidE),     128'(valid));
        check({tag, ".RegWriteE"},  128'(deIf.RegWriteE),  128'(regWr));
        check({tag, ".FlagWriteE"}, 128'(deIf.FlagWriteE), 128'(fw));
        check({tag, ".CondE"},      128'(deIf.CondE),      128'(cond));
        check({tag, ".WA3E"},       128'(deIf.WA3E),       128'(wa3));
        check({tag, ".RD1E"},       128'(deIf.RD1E),       128'(rd1));
        check({tag, ".otherE"},     128'(sideE()),         128'(sideOf(rd1)));
        check({tag, ".FlagsE"},     128'(deIf.FlagsE),     128'(flags));
    endtask

    function automatic vec_t mk(input logic rst, input logic stall, input logic flush,
                                input logic regWr, input logic [1:0] fw, input logic [3:0] cond,
                                input logic [3:0] wa3, input logic [31:0] rd1,
                                input logic [3:0] aluF, input logic condEx,
                                input logic eV, input logic eRw, input logic [1:0] eFw,
                                input logic [3:0] eCond, input logic [3:0] eWa3,
                                input logic [31:0] eRd1, input logic [3:0] eFlags);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.regWr = regWr; v.fw = fw;
        v.cond = cond; v.wa3 = wa3; v.rd1 = rd1; v.aluF = aluF; v.condEx = condEx;
        v.expValid = eV; v.expRegWr = eRw; v.expFw = eFw; v.expCond = eCond;
        v.expWa3 = eWa3; v.expRd1 = eRd1; v.expFlags = eFlags;
        return v;
    endfunction

    // Drive on the posedge+1 step, step one edge, sample 1 time unit later.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst st fl rw fw     cond  wa3   rd1           aluF  cx | V  Rw eFw    eCond eWa3  eRd1          eFlags
        vecs[0]  = mk(0, 0, 0, 1, 2'b11, 4'hE, 4'h5, 32'hDEADBEEF, 4'hF, 1,  0, 0, 2'b00, 4'h0, 4'h0, 32'h0,        4'b0000);
        vecs[1]  = mk(0, 0, 0, 1, 2'b11, 4'hE, 4'h7, 32'hCAFEF00D, 4'hF, 1,  0, 0, 2'b00, 4'h0, 4'h0, 32'h0,        4'b0000);
        vecs[2]  = mk(1, 0, 0, 1, 2'b00, 4'hE, 4'h3, 32'h00001234, 4'hF, 1,  1, 1, 2'b00, 4'hE, 4'h3, 32'h00001234, 4'b0000);
        vecs[3]  = mk(1, 0, 0, 0, 2'b11, 4'hE, 4'h1, 32'h00000040, 4'hF, 1,  1, 0, 2'b11, 4'hE, 4'h1, 32'h00000040, 4'b0000);
        vecs[4]  = mk(1, 1, 0, 1, 2'b00, 4'h5, 4'h9, 32'h0000AAAA, 4'h6, 1,  1, 0, 2'b11, 4'hE, 4'h1, 32'h00000040, 4'b0000);
        vecs[5]  = mk(1, 1, 0, 0, 2'b01, 4'h3, 4'hA, 32'h0000BBBB, 4'h6, 1,  1, 0, 2'b11, 4'hE, 4'h1, 32'h00000040, 4'b0000);
        vecs[6]  = mk(1, 1, 0, 1, 2'b10, 4'h2, 4'hB, 32'h0000CCCC, 4'h6, 1,  1, 0, 2'b11, 4'hE, 4'h1, 32'h00000040, 4'b0000);
        vecs[7]  = mk(1, 0, 0, 1, 2'b10, 4'h0, 4'h2, 32'h00000055, 4'h6, 1,  1, 1, 2'b10, 4'h0, 4'h2, 32'h00000055, 4'b0110);
        vecs[8]  = mk(1, 0, 0, 1, 2'b01, 4'h0, 4'h4, 32'h00000066, 4'hF, 1,  1, 1, 2'b01, 4'h0, 4'h4, 32'h00000066, 4'b1110);
        vecs[9]  = mk(1, 0, 0, 0, 2'b10, 4'h1, 4'h6, 32'h00000077, 4'h3, 1,  1, 0, 2'b10, 4'h1, 4'h6, 32'h00000077, 4'b1111);
        vecs[10] = mk(1, 0, 0, 1, 2'b11, 4'hE, 4'h8, 32'h00000088, 4'h0, 1,  1, 1, 2'b11, 4'hE, 4'h8, 32'h00000088, 4'b0011);
        vecs[11] = mk(1, 0, 0, 1, 2'b11, 4'hE, 4'h9, 32'h00000099, 4'hC, 0,  1, 1, 2'b11, 4'hE, 4'h9, 32'h00000099, 4'b0011);
        vecs[12] = mk(1, 1, 1, 1, 2'b11, 4'hE, 4'h5, 32'h000000A5, 4'h8, 1,  0, 0, 2'b00, 4'h0, 4'h0, 32'h0,        4'b0011);
        vecs[13] = mk(1, 0, 1, 1, 2'b11, 4'hE, 4'h5, 32'h000000B5, 4'hF, 1,  0, 0, 2'b00, 4'h0, 4'h0, 32'h0,        4'b0011);
        vecs[14] = mk(1, 0, 0, 1, 2'b11, 4'hE, 4'hC, 32'h000000C5, 4'hF, 1,  1, 1, 2'b11, 4'hE, 4'hC, 32'h000000C5, 4'b0011);
        vecs[15] = mk(1, 0, 1, 1, 2'b00, 4'hE, 4'hD, 32'h000000D5, 4'h8, 1,  0, 0, 2'b00, 4'h0, 4'h0, 32'h0,        4'b1000);
        vecs[16] = mk(1, 0, 0, 1, 2'b11, 4'hE, 4'h6, 32'h000000E5, 4'hF, 1,  1, 1, 2'b11, 4'hE, 4'h6, 32'h000000E5, 4'b1000);
        vecs[17] = mk(0, 0, 0, 1, 2'b11, 4'hE, 4'h7, 32'h000000F5, 4'h5, 1,  0, 0, 2'b00, 4'h0, 4'h0, 32'h0,        4'b0000);
        vecs[18] = mk(1, 0, 0, 0, 2'b01, 4'hA, 4'h3, 32'h00000105, 4'hF, 1,  1, 0, 2'b01, 4'hA, 4'h3, 32'h00000105, 4'b0000);

        reset = 1'b0;
        deIf.StallE = 1'b0;
        deIf.FlushE = 1'b0;
        deIf.ALUFlagsE = 4'h0;
        deIf.CondExE = 1'b0;
        driveD(1'b0, 2'b00, 4'h0, 4'h0, 32'h0);
        #2;

        for (int i = 0; i < 19; i++) begin
            reset = vecs[i].rst;
            deIf.StallE = vecs[i].stall;
            deIf.FlushE = vecs[i].flush;
            deIf.ALUFlagsE = vecs[i].aluF;
            deIf.CondExE = vecs[i].condEx;
            driveD(vecs[i].regWr, vecs[i].fw, vecs[i].cond, vecs[i].wa3, vecs[i].rd1);
            stepEdge();
            checkE($sformatf("v%0d", i), vecs[i].expValid, vecs[i].expRegWr, vecs[i].expFw,
                   vecs[i].expCond, vecs[i].expWa3, vecs[i].expRd1, vecs[i].expFlags);
        end

        // E holds a C,V setter (FlagWriteE=01). Stall it two cycles with the
        // condition passing; the flags must change only on the release edge.
        deIf.StallE = 1'b1;
        deIf.CondExE = 1'b1;
        deIf.ALUFlagsE = 4'b0011;
        driveD(1'b1, 2'b00, 4'h1, 4'h8, 32'h00000200);
        stepEdge();
        checkE("stall1", 1, 0, 2'b01, 4'hA, 4'h3, 32'h00000105, 4'b0000);
        driveD(1'b1, 2'b00, 4'h2, 4'h9, 32'h00000300);
        stepEdge();
        checkE("stall2", 1, 0, 2'b01, 4'hA, 4'h3, 32'h00000105, 4'b0000);
        deIf.StallE = 1'b0;
        driveD(1'b1, 2'b00, 4'h4, 4'hB, 32'h00000400);
        stepEdge();
        checkE("release", 1, 1, 2'b00, 4'h4, 4'hB, 32'h00000400, 4'b0011);
        // The non-setting successor must leave the flags as written once.
        deIf.ALUFlagsE = 4'b1100;
        driveD(1'b0, 2'b00, 4'h0, 4'h0, 32'h0);
        stepEdge();
        checkE("after", 1, 0, 2'b00, 4'h0, 4'h0, 32'h0, 4'b0011);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decode_execute_reg.md
# decode_execute_reg

Pipeline register between the decode and execute stages of the pipelined core. It captures decode-stage control and data fields each cycle and presents them to the execute stage. It supports hold (stall) and bubble insertion (flush). It also owns the architectural condition-flag register that feeds the execute-stage condition check; that register is updated from the ALU flags when the executing instruction passes its condition.

## Interface
- DATA_WIDTH, 32: width of register-file operands and extended immediate
- REG_ADDR_W, 4: width of register addresses
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- StallE  in  1  hold all pipeline fields
- FlushE  in  1  load a bubble instead of decode fields
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD  in  1 each  decode control bits
- ALUControlD  in  3  ALU operation select
- FlagWriteD  in  2  bit1 = write N,Z; bit0 = write C,V
- CondD  in  4  condition field
- RD1D, RD2D, ExtImmD  in  DATA_WIDTH each  operands and immediate
- WA3D, RA1D, RA2D  in  REG_ADDR_W each  destination and source register addresses
- ALUFlagsE  in  4  {N,Z,C,V} from execute ALU
- CondExE  in  1  condition-passed from execute condition check
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, NoWriteE  out  1 each  registered control
- ALUControlE  out  3; FlagWriteE  out  2; CondE  out  4
- RD1E, RD2E, ExtImmE  out  DATA_WIDTH each
- WA3E, RA1E, RA2E  out  REG_ADDR_W each
- ValidE  out  1  execute slot holds a real instruction (not a bubble)
- FlagsE  out  4  architectural flags {N,Z,C,V}

## Operation
- All outputs are registers. There is no combinational path from inputs to outputs.
- Pipeline field update priority per edge: reset low > FlushE > StallE > load.
  - reset low: every pipeline output 0, ValidE 0, FlagsE 4'b0000.
  - FlushE=1: all control bits, ALUControlE, FlagWriteE, CondE, data and address fields load 0; ValidE loads 0. FlushE overrides StallE.
  - StallE=1 (no flush): all pipeline fields and ValidE hold.
  - Otherwise: each *E field loads its *D counterpart; ValidE loads 1.
- Flag register update enable: FlagUpd = reset & ValidE & CondExE & ~StallE.
  - This uses the instruction currently in E, before the edge.
  - FlushE does not suppress FlagUpd; flush only affects the incoming instruction.
- When FlagUpd=1:
  - FlagWriteE[1]=1: FlagsE[3:2] ← ALUFlagsE[3:2].
  - FlagWriteE[0]=1: FlagsE[1:0] ← ALUFlagsE[1:0].
  - Unselected bits hold.
- When FlagUpd=0: FlagsE holds.
- Stall suppresses the flag write so that a held instruction writes flags exactly once, on the edge where it leaves E.

## Timing
- Latency: 1 cycle from D inputs to E outputs.
- FlagsE changes on the same edge the flag-setting instruction leaves E, so the next instruction sees new flags in its first E cycle. No flag hazard bubble is needed.
- Reset: takes effect on the first rising edge with reset=0. Outputs are valid-zero from that edge. The first load occurs on the first edge with reset=1.
- Reset mid-operation discards the E instruction and its pending flag update.
- Bubble output: all write-enables and BranchE/PCSrcE are 0. Downstream gating therefore produces no side effects regardless of CondExE.
- Simultaneous FlushE and StallE: bubble loaded; FlagUpd is still blocked by StallE.

## Test plan
- Reset: drive reset=0 with random D inputs for 2 edges -> all outputs 0, ValidE=0, FlagsE=0000. Release reset with RegWriteD=1, WA3D=4'h3, RD1D=32'h1234 -> next edge RegWriteE=1, WA3E=3, RD1E=32'h1234, ValidE=1.
- Stall/flush: StallE=1 for 3 cycles while D inputs change -> E outputs hold the pre-stall values. Then FlushE=1 with StallE=1 -> all fields 0, ValidE=0.
- Flag write, condition passed: E holds FlagWriteE=2'b11, ValidE=1, CondExE=1, ALUFlagsE=4'b0110 -> FlagsE=0110 after edge. Following instruction's CondE=0 (EQ) sees Z=1.
- Partial flag write: FlagsE=1111, FlagWriteE=2'b10, ALUFlagsE=0000, CondExE=1 -> FlagsE=0011.
- Blocked flag writes:
  - CondExE=0 with FlagWriteE=11 -> FlagsE unchanged.
  - Bubble in E (ValidE=0) with CondExE=1 -> FlagsE unchanged.
  - StallE=1 for 2 cycles on a flag-setting instruction -> FlagsE updates only on the release edge, exactly once.
- Flush with flag setter in E: FlushE=1 while E holds FlagWriteE=11, CondExE=1, ALUFlagsE=1000 -> FlagsE=1000 and E becomes bubble on same edge.
